// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg: shared constants and types for the IF/ID decoupling buffer.
// Holds the reset level, default depth, queue-operation encoding and a helper.
package if_id_buf_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam int IF_ID_DEPTH = 2;

    // Encoding is {push, pop} so the op can be built by a plain cast.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// if_id_buf_if: fetch-side and decode-side valid/ready handshake bundle.
// master = fetch/decode stages (drive if_*, id_ready); slave = the buffer.
interface if_id_buf_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);

    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst
    );

endinterface

// File: rtl/if_id_buf.sv
// if_id_buf: DEPTH-entry circular queue of (pc, inst) between fetch and decode.
// Ports: clk, rst (sync, active-high), flush, bus (slave handshake), count.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int INST_W = 32,
    parameter  int DEPTH  = IF_ID_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    if_id_buf_if.slave       bus,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
            $error("if_id_buf: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              clear;
    q_op_e             op;

    // Ready/valid come from registered occupancy only, so a decode stall
    // never reaches fetch combinationally.
    assign bus.if_ready = (count != CNT_W'(DEPTH));
    assign bus.id_valid = (count != '0);
    assign bus.id_pc    = bus.id_valid ? pc_q[rd_ptr]   : '0;
    assign bus.id_inst  = bus.id_valid ? inst_q[rd_ptr] : '0;

    assign push  = bus.if_valid & bus.if_ready;
    assign pop   = bus.id_valid & bus.id_ready;
    assign clear = (rst == RST_ENABLE) | flush;

    always_comb begin
        op = q_op_e'({push, pop});
    end

    // Storage is not cleared; entries past count are don't-care.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_q[wr_ptr]   <= bus.if_pc;
            inst_q[wr_ptr] <= bus.if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case (op)
                OP_PUSH: count <= count + CNT_W'(1);
                OP_POP:  count <= count - CNT_W'(1);
                OP_IDLE: count <= count;
                OP_BOTH: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: scoreboard bench for if_id_buf with DEPTH=2 and DEPTH=4 copies.
// Stimulus queues expected entries; a negedge monitor checks every pop.
module tb_if_id_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        sel;
    logic        vld;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    logic        o_v;
    logic        o_ifr;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [2:0]  o_cnt;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    if_id_buf_if b2 ();
    if_id_buf_if b4 ();

    if_id_buf #(.DEPTH(2)) u2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b2),
        .count (cnt2)
    );

    if_id_buf #(.DEPTH(4)) u4 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b4),
        .count (cnt4)
    );

    // sel picks the active copy; the idle copy sees no traffic.
    assign b2.if_valid = vld & ~sel;
    assign b4.if_valid = vld & sel;
    assign b2.id_ready = rdy & ~sel;
    assign b4.id_ready = rdy & sel;
    assign b2.if_pc    = pc;
    assign b4.if_pc    = pc;
    assign b2.if_inst  = inst;
    assign b4.if_inst  = inst;

    assign o_v    = sel ? b4.id_valid : b2.id_valid;
    assign o_ifr  = sel ? b4.if_ready : b2.if_ready;
    assign o_pc   = sel ? b4.id_pc    : b2.id_pc;
    assign o_inst = sel ? b4.id_inst  : b2.id_inst;
    assign o_cnt  = sel ? cnt4 : {1'b0, cnt2};

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && !flush && o_v && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_extra: got pc %h want none", o_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", o_pc, e[63:32]);
                chk("pop_inst", o_inst, e[31:0]);
            end
        end
    end

    // One clock: drive, check if_ready, log the expected entry, advance.
    task automatic step(input logic v, input logic [31:0] p,
                        input logic [31:0] i, input logic r,
                        input logic acc, input logic f,
                        input logic rs);
        vld   = v;
        pc    = p;
        inst  = i;
        rdy   = r;
        flush = f;
        rst   = rs;
        @(negedge clk);
        if (v && !rs) chk("if_ready", 32'(o_ifr), 32'(acc));
        if (f || rs) exp_q.delete();
        else if (v && acc) exp_q.push_back({p, i});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_cnt"}, 32'(o_cnt), 32'd0);
        chk({nm, "_v"}, 32'(o_v), 32'd0);
        chk({nm, "_pc"}, o_pc, 32'd0);
        chk({nm, "_inst"}, o_inst, 32'd0);
        chk({nm, "_ifr"}, 32'(o_ifr), 32'd1);
    endtask

    initial begin
        sel   = 1'b0;
        rst   = 1'b1;
        flush = 1'b0;
        vld   = 1'b1;
        rdy   = 1'b0;
        pc    = 32'hdead;
        inst  = 32'hbeef;

        // Reset held with if_valid=1: nothing captured.
        step(1, 32'hdead, 32'hbeef, 0, 0, 0, 1);
        step(1, 32'hdead, 32'hbeef, 0, 0, 0, 1);
        idle_chk("rst");
        step(0, 0, 0, 0, 0, 0, 0);
        idle_chk("rst_rel");

        // Streaming on DEPTH=2.
        step(1, 32'h0, 32'h11, 1, 1, 0, 0);
        chk("s0_cnt", 32'(o_cnt), 32'd1);
        chk("s0_pc", o_pc, 32'h0);
        chk("s0_inst", o_inst, 32'h11);
        step(1, 32'h4, 32'h22, 1, 1, 0, 0);
        chk("s1_cnt", 32'(o_cnt), 32'd1);
        chk("s1_pc", o_pc, 32'h4);
        step(1, 32'h8, 32'h33, 1, 1, 0, 0);
        chk("s2_cnt", 32'(o_cnt), 32'd1);
        chk("s2_inst", o_inst, 32'h33);
        step(0, 0, 0, 1, 0, 0, 0);
        idle_chk("s_end");

        // Stall and fill DEPTH=2.
        step(1, 32'h100, 32'ha0, 0, 1, 0, 0);
        chk("f0_cnt", 32'(o_cnt), 32'd1);
        step(1, 32'h104, 32'ha4, 0, 1, 0, 0);
        chk("f1_cnt", 32'(o_cnt), 32'd2);
        chk("f1_ifr", 32'(o_ifr), 32'd0);
        step(1, 32'h108, 32'ha8, 0, 0, 0, 0);
        chk("f2_cnt", 32'(o_cnt), 32'd2);
        chk("f2_head", o_pc, 32'h100);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("f3_cnt", 32'(o_cnt), 32'd1);
        chk("f3_ifr", 32'(o_ifr), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("f4_cnt", 32'(o_cnt), 32'd0);
        step(1, 32'h108, 32'ha8, 1, 1, 0, 0);
        chk("f5_pc", o_pc, 32'h108);
        step(0, 0, 0, 1, 0, 0, 0);
        idle_chk("f_end");

        // Push+pop at count=1 across pointer wrap, DEPTH=4.
        sel = 1'b1;
        step(1, 32'h300, 32'h3000, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(1, 32'h300 + 32'(4 * k), 32'h3000 + 32'(k),
                 1, 1, 0, 0);
            chk("w_cnt", 32'(o_cnt), 32'd1);
        end
        chk("w_head", o_pc, 32'h328);
        step(0, 0, 0, 1, 0, 0, 0);
        idle_chk("w_end");

        // Flush with push and pop in the same cycle at count=2.
        step(1, 32'h400, 32'h40, 0, 1, 0, 0);
        step(1, 32'h404, 32'h44, 0, 1, 0, 0);
        chk("fl_cnt2", 32'(o_cnt), 32'd2);
        step(1, 32'h408, 32'h48, 1, 1, 1, 0);
        idle_chk("fl");
        step(1, 32'h40c, 32'h4c, 1, 1, 0, 0);
        chk("fl_next", o_pc, 32'h40c);
        step(0, 0, 0, 1, 0, 0, 0);

        // Reset mid-stream at count=3, DEPTH=4.
        step(1, 32'h500, 32'h50, 0, 1, 0, 0);
        step(1, 32'h504, 32'h54, 0, 1, 0, 0);
        step(1, 32'h508, 32'h58, 0, 1, 0, 0);
        chk("r_cnt3", 32'(o_cnt), 32'd3);
        step(0, 0, 0, 1, 0, 0, 1);
        idle_chk("r_mid");
        step(1, 32'h200, 32'h20, 0, 1, 0, 0);
        chk("r_first", o_pc, 32'h200);
        step(1, 32'h204, 32'h24, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle_chk("r_end");

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
